// File: rtl/ex_div.sv
// ex_div : 32-bit radix-2 restoring divider for the EX stage.
//
// One quotient bit is produced per cycle. The divide takes 34 edges from
// start to ready_o. A zero divisor completes in 2 edges with an all-zero
// result.
//
// Ports
//   Clk           in   1   sole clock, all state updates on posedge
//   Rst_n         in   1   synchronous active-low reset
//   signed_div_i  in   1   1 = two's-complement divide, 0 = unsigned
//   opdata1_i     in  32   dividend
//   opdata2_i     in  32   divisor
//   start_i       in   1   divide request, held by EX until ready_o
//   annul_i       in   1   abort current divide (pipeline flush)
//   result_o      out 64   {remainder, quotient}, zero unless ready_o
//   ready_o       out  1   result_o valid
//
// Configuration
//   EX_DIV_SIGNED_EN  defined   : signed_div_i selects signed division
//                     undefined : all divides unsigned, signed_div_i unused
module ex_div (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  localparam logic RST_ENABLE = 1'b0;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'd0,
    DIV_BYZERO = 2'd1,
    DIV_ON     = 2'd2,
    DIV_END    = 2'd3
  } state_e;

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic [63:0] work_q;
  logic [63:0] work_d;
  logic [31:0] divisor_q;

  logic [31:0] mag1;
  logic [31:0] mag2;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;
  logic [63:0] shifted;

`ifdef EX_DIV_SIGNED_EN
  logic neg_quot_q;
  logic neg_rem_q;

  // Negation of 0x80000000 wraps to itself, which is the wanted magnitude.
  always_comb begin
    mag1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    mag2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
    quot_fix = neg_quot_q ? (~work_q[31:0] + 32'd1)  : work_q[31:0];
    rem_fix  = neg_rem_q  ? (~work_q[63:32] + 32'd1) : work_q[63:32];
  end
`else
  logic unused_signed_div;
  assign unused_signed_div = signed_div_i;

  always_comb begin
    mag1     = opdata1_i;
    mag2     = opdata2_i;
    quot_fix = work_q[31:0];
    rem_fix  = work_q[63:32];
  end
`endif

  // One restoring step: shift in a zero, subtract when the partial
  // remainder covers the divisor and set the new quotient bit.
  always_comb begin
    shifted = {work_q[62:0], 1'b0};
    if (shifted[63:32] >= divisor_q) begin
      work_d = {shifted[63:32] - divisor_q, shifted[31:1], 1'b1};
    end else begin
      work_d = shifted;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst_n == RST_ENABLE) begin
      state_q   <= DIV_FREE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      result_o  <= '0;
      ready_o   <= 1'b0;
`ifdef EX_DIV_SIGNED_EN
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        DIV_FREE: begin
          result_o <= '0;
          ready_o  <= 1'b0;
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              state_q <= DIV_BYZERO;
            end else begin
              state_q   <= DIV_ON;
              divisor_q <= mag2;
              work_q    <= {32'h0, mag1};
              cnt_q     <= '0;
`ifdef EX_DIV_SIGNED_EN
              neg_quot_q <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
              neg_rem_q  <= signed_div_i && opdata1_i[31];
`endif
            end
          end
        end

        DIV_BYZERO: begin
          result_o <= '0;
          if (annul_i) begin
            state_q <= DIV_FREE;
            ready_o <= 1'b0;
          end else begin
            state_q <= DIV_END;
            ready_o <= 1'b1;
          end
        end

        DIV_ON: begin
          if (annul_i) begin
            state_q  <= DIV_FREE;
            result_o <= '0;
            ready_o  <= 1'b0;
          end else if (cnt_q != 6'd32) begin
            work_q <= work_d;
            cnt_q  <= cnt_q + 6'd1;
          end else begin
            state_q  <= DIV_END;
            result_o <= {rem_fix, quot_fix};
            ready_o  <= 1'b1;
          end
        end

        DIV_END: begin
          if (annul_i || !start_i) begin
            state_q  <= DIV_FREE;
            result_o <= '0;
            ready_o  <= 1'b0;
          end
        end

        default: begin
          state_q  <= DIV_FREE;
          result_o <= '0;
          ready_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div : directed self-checking bench for ex_div.
//
// A transaction-level reference (plain / and % on operand magnitudes plus a
// cycle countdown) predicts ready_o/result_o every cycle; directed cases also
// carry hand-computed literal results and latencies. Expectations for signed
// cases follow whether EX_DIV_SIGNED_EN is defined.
module tb_ex_div;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  ex_div dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

`ifdef EX_DIV_SIGNED_EN
  localparam logic [63:0] EXP_NEG7_2 = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
  localparam logic [63:0] EXP_7_NEG2 = {32'h0000_0001, 32'hFFFF_FFFD};
  localparam logic [63:0] EXP_MIN    = {32'h0000_0000, 32'h8000_0000};
`else
  localparam logic [63:0] EXP_NEG7_2 = {32'h0000_0001, 32'h7FFF_FFFC};
  localparam logic [63:0] EXP_7_NEG2 = {32'h0000_0007, 32'h0000_0000};
  localparam logic [63:0] EXP_MIN    = {32'h8000_0000, 32'h0000_0000};
`endif

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    logic        sg;
    logic [31:0] ma, mb, q, r;
`ifdef EX_DIV_SIGNED_EN
    sg = s;
`else
    sg = s & 1'b0;
`endif
    if (b == 32'd0) return 64'd0;
    ma = (sg && a[31]) ? (32'd0 - a) : a;
    mb = (sg && b[31]) ? (32'd0 - b) : b;
    q = ma / mb;
    r = ma % mb;
    if (sg && (a[31] != b[31])) q = 32'd0 - q;
    if (sg && a[31]) r = 32'd0 - r;
    return {r, q};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: accepted divide completes 33 edges after acceptance,
  // a zero divisor 1 edge after; annul/reset drop everything.
  int          m_rem = 0;
  bit          m_done = 1'b0;
  logic [63:0] m_pend = '0;
  logic [63:0] m_res = '0;

  always @(posedge Clk) begin
    if (!Rst_n) begin
      m_rem  <= 0;
      m_done <= 1'b0;
      m_res  <= '0;
    end else if (m_done) begin
      if (annul_i || !start_i) begin
        m_done <= 1'b0;
        m_res  <= '0;
      end
    end else if (m_rem > 0) begin
      if (annul_i) begin
        m_rem <= 0;
      end else begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_done <= 1'b1;
          m_res  <= m_pend;
        end
      end
    end else if (start_i && !annul_i) begin
      m_rem  <= (opdata2_i == 32'd0) ? 1 : 33;
      m_pend <= ref_div(opdata1_i, opdata2_i, signed_div_i);
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("cyc ready_o", {63'd0, ready_o}, {63'd0, m_done});
      chk("cyc result_o", result_o, m_done ? m_res : 64'd0);
    end
  end

  // Caller is positioned #1 after an edge; that edge is "edge 0".
  task automatic run_div(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input int lat, input logic [63:0] exp,
                         input int hold, input bit scramble);
    int s_cyc;
    int n;
    s_cyc = cyc;
    opdata1_i    = a;
    opdata2_i    = b;
    signed_div_i = s;
    start_i      = 1'b1;
    n = 0;
    do begin
      @(posedge Clk); #1;
      n++;
      if (scramble && n == 5) begin
        opdata1_i    = 32'd5;
        opdata2_i    = 32'd0;
        signed_div_i = ~s;
      end
    end while (!ready_o && n < 200);
    chk({nm, " ready"}, {63'd0, ready_o}, 64'd1);
    chk({nm, " latency"}, 64'(cyc - s_cyc), 64'(lat));
    chk({nm, " result"}, result_o, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge Clk); #1;
      chk({nm, " hold ready"}, {63'd0, ready_o}, 64'd1);
      chk({nm, " hold result"}, result_o, exp);
    end
    start_i = 1'b0;
    @(posedge Clk); #1;
    chk({nm, " release ready"}, {63'd0, ready_o}, 64'd0);
    chk({nm, " release result"}, result_o, 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    start_i = 1'b1;
    opdata1_i = 32'd77;
    opdata2_i = 32'd3;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset ready", {63'd0, ready_o}, 64'd0);
    chk("reset result", result_o, 64'd0);
    start_i = 1'b0;
    chk_en  = 1'b1;
    Rst_n   = 1'b1;
    @(posedge Clk); #1;

    run_div("u100/7",     32'd100,       32'd7,         1'b0, 34, {32'd2, 32'd14}, 2, 1'b0);
    run_div("s-7/2",      32'hFFFF_FFF9, 32'd2,         1'b1, 34, EXP_NEG7_2,      0, 1'b0);
    run_div("divzero",    32'h1234,      32'd0,         1'b0, 2,  64'd0,           1, 1'b0);
    run_div("uffff/1",    32'hFFFF_FFFF, 32'd1,         1'b0, 34, {32'd0, 32'hFFFF_FFFF}, 0, 1'b0);
    run_div("uffff/8001", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 34, {32'h7FFF_FFFE, 32'd1}, 0, 1'b0);
    run_div("u5/10",      32'd5,         32'd10,        1'b0, 34, {32'd5, 32'd0},  0, 1'b0);
    run_div("s7/-2",      32'd7,         32'hFFFF_FFFE, 1'b1, 34, EXP_7_NEG2,      0, 1'b0);
    run_div("latched",    32'd1000,      32'd10,        1'b0, 34, {32'd0, 32'd100}, 0, 1'b1);

    // Annul mid-divide, then a fresh divide
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    signed_div_i = 1'b0;
    start_i = 1'b1;
    repeat (10) @(posedge Clk);
    #1;
    start_i = 1'b0;
    annul_i = 1'b1;
    @(posedge Clk); #1;
    annul_i = 1'b0;
    chk("annul ready", {63'd0, ready_o}, 64'd0);
    chk("annul result", result_o, 64'd0);
    @(posedge Clk); #1;
    run_div("post-annul 9/3", 32'd9, 32'd3, 1'b0, 34, {32'd0, 32'd3}, 0, 1'b0);

    // Reset mid-divide, then the signed wrap case
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    repeat (20) @(posedge Clk);
    #1;
    Rst_n = 1'b0;
    @(posedge Clk); #1;
    chk("midreset ready", {63'd0, ready_o}, 64'd0);
    chk("midreset result", result_o, 64'd0);
    Rst_n = 1'b1;
    start_i = 1'b0;
    @(posedge Clk); #1;
    run_div("s-min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 34, EXP_MIN, 0, 1'b0);

    // Annul while a zero-divisor result is being held
    opdata1_i = 32'd1;
    opdata2_i = 32'd0;
    start_i = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("byzero held ready", {63'd0, ready_o}, 64'd1);
    annul_i = 1'b1;
    @(posedge Clk); #1;
    annul_i = 1'b0;
    start_i = 1'b0;
    chk("end annul ready", {63'd0, ready_o}, 64'd0);
    repeat (2) @(posedge Clk);
    #1;

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
